// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } serial_adder_state_t;

  localparam int SERIAL_ADDER_MAX_WIDTH = 32;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder built from two half-adder cells; the datapath of serial_adder_ctrl.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full adder reused LSB-first across WIDTH bits.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for a-b (two's complement).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  import serial_adder_pkg::*;

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_adder_state_t state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_init;
  logic             fa_s;
  logic             fa_c;
  logic             accept;

  assign accept = in_valid && in_ready;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: invert B on load and seed the carry.
  assign b_load = sub ? ~b : b;
  assign c_init = sub;
`else
  assign b_load = b;
  assign c_init = 1'b0;
`endif

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // The result shifter only needs the upper WIDTH-1 bits; bit 0 is dropped each step.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = fa_s;
    end else begin : g_res_multi
      logic [WIDTH-2:0] res_sh;

      always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
          res_sh <= '0;
        end else if (state == SHIFT) begin
          res_sh <= res_next[WIDTH-1:1];
        end
      end

      assign res_next = {fa_s, res_sh};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh     <= a;
            b_sh     <= b_load;
            carry    <= c_init;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            sum       <= res_next;
            carry_out <= fa_c;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
